// File: rtl/aes_core_sched.sv
// Round-robin scheduler that shares one AES core between NB_REQ block requesters.
// Key expansion is re-run only when the key context (owner or key) changes.
module aes_core_sched #(
  parameter int unsigned NB_REQ = 2,
  parameter int unsigned KEY_W  = 256,
  parameter int unsigned BLK_W  = 128
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic [NB_REQ-1:0]         req_valid_i,
  output logic [NB_REQ-1:0]         req_ready_o,
  input  logic [NB_REQ*KEY_W-1:0]   req_key_i,
  input  logic [NB_REQ-1:0]         req_keylen_i,
  input  logic [NB_REQ-1:0]         req_encdec_i,
  input  logic [NB_REQ*BLK_W-1:0]   req_block_i,
  input  logic [NB_REQ-1:0]         key_update_i,
  output logic [NB_REQ-1:0]         rsp_valid_o,
  input  logic [NB_REQ-1:0]         rsp_ready_i,
  output logic [BLK_W-1:0]          rsp_block_o,
  output logic                      core_init_o,
  output logic                      core_next_o,
  output logic [KEY_W-1:0]          core_key_o,
  output logic                      core_keylen_o,
  output logic                      core_encdec_o,
  output logic [BLK_W-1:0]          core_block_o,
  input  logic                      core_ready_i,
  input  logic [BLK_W-1:0]          core_result_i,
  input  logic                      core_result_valid_i,
  output logic [$clog2(NB_REQ)-1:0] grant_id_o,
  output logic                      busy_o,
  output logic [31:0]               blocks_done_o
);
  localparam int unsigned ID_W  = $clog2(NB_REQ);
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_INIT  = 3'd1,
    KEY_WAIT  = 3'd2,
    BLK_START = 3'd3,
    BLK_WAIT  = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            wait_guard;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] key_owner;
  logic [ID_W-1:0] sel;
  logic            key_loaded;
  logic            found;
  logic            grant;
  logic            key_reuse;
  logic            rsp_done;

  // Round-robin search for the first pending requester starting at rr_ptr.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      if (!found && req_valid_i[ID_W'(idx)]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  // A key update for the selected requester in the grant cycle forces a reload.
  assign key_reuse = key_loaded && (key_owner == sel) && !key_update_i[sel];
  assign rsp_done  = (state == RESP) && rsp_ready_i[grant_id_o];

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (found && core_ready_i) begin
          grant      = 1'b1;
          state_next = key_reuse ? BLK_START : KEY_INIT;
        end
      end
      KEY_INIT:  state_next = KEY_WAIT;
      KEY_WAIT:  if (!wait_guard && core_ready_i) state_next = BLK_START;
      BLK_START: state_next = BLK_WAIT;
      BLK_WAIT:  if (!wait_guard && core_ready_i && core_result_valid_i) state_next = RESP;
      RESP:      if (rsp_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (clear) begin
      state_next = IDLE;
      grant      = 1'b0;
    end
  end

  // wait_guard is high in the first cycle of any state, masking stale core_ready_i.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_guard <= 1'b0;
    end else begin
      state      <= state_next;
      wait_guard <= (state_next != state);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id_o    <= '0;
      rr_ptr        <= '0;
      key_owner     <= '0;
      key_loaded    <= 1'b0;
      core_key_o    <= '0;
      core_keylen_o <= 1'b0;
      core_encdec_o <= 1'b0;
      core_block_o  <= '0;
      rsp_block_o   <= '0;
      blocks_done_o <= '0;
    end else if (clear) begin
      grant_id_o    <= '0;
      rr_ptr        <= '0;
      key_owner     <= '0;
      key_loaded    <= 1'b0;
      core_key_o    <= '0;
      core_keylen_o <= 1'b0;
      core_encdec_o <= 1'b0;
      core_block_o  <= '0;
      rsp_block_o   <= '0;
      blocks_done_o <= '0;
    end else begin
      if (grant) begin
        grant_id_o    <= sel;
        core_key_o    <= req_key_i[32'(sel)*KEY_W +: KEY_W];
        core_keylen_o <= req_keylen_i[sel];
        core_encdec_o <= req_encdec_i[sel];
        core_block_o  <= req_block_i[32'(sel)*BLK_W +: BLK_W];
      end
      if (state == KEY_INIT) begin
        key_owner  <= grant_id_o;
        key_loaded <= 1'b0;
      end
      if (state == KEY_WAIT && state_next == BLK_START) key_loaded <= 1'b1;
      // Placed last so an owner key update wins over a completing expansion.
      if (key_update_i[key_owner]) key_loaded <= 1'b0;
      if (state == BLK_WAIT && state_next == RESP) rsp_block_o <= core_result_i;
      if (rsp_done) begin
        blocks_done_o <= blocks_done_o + CNT_W'(1);
        rr_ptr        <= (grant_id_o == ID_W'(NB_REQ - 1)) ? '0 : grant_id_o + ID_W'(1);
      end
    end
  end

  assign req_ready_o = grant ? (NB_REQ'(1) << sel) : '0;
  assign rsp_valid_o = (state == RESP) ? (NB_REQ'(1) << grant_id_o) : '0;
  assign core_init_o = (state == KEY_INIT);
  assign core_next_o = (state == BLK_START);
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_aes_core_sched.sv
// Bench for aes_core_sched: behavioural core model, request/response model and
// directed scenarios with literal expectations.
module tb_aes_core_sched;
  localparam int unsigned NB = 2;
  localparam int unsigned KW = 256;
  localparam int unsigned BW = 128;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic           clk, reset_n, clear;
  logic [NB-1:0]  req_valid_i, req_ready_o, req_keylen_i, req_encdec_i, key_update_i;
  logic [NB*KW-1:0] req_key_i;
  logic [NB*BW-1:0] req_block_i;
  logic [NB-1:0]  rsp_valid_o, rsp_ready_i;
  logic [BW-1:0]  rsp_block_o, core_block_o, core_result_i;
  logic           core_init_o, core_next_o, core_keylen_o, core_encdec_o;
  logic [KW-1:0]  core_key_o;
  logic           core_ready_i, core_result_valid_i, busy_o;
  logic [0:0]     grant_id_o;
  logic [31:0]    blocks_done_o;

  aes_core_sched #(.NB_REQ(NB), .KEY_W(KW), .BLK_W(BW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_key_i(req_key_i),
    .req_keylen_i(req_keylen_i), .req_encdec_i(req_encdec_i), .req_block_i(req_block_i),
    .key_update_i(key_update_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_block_o(rsp_block_o), .core_init_o(core_init_o), .core_next_o(core_next_o),
    .core_key_o(core_key_o), .core_keylen_o(core_keylen_o), .core_encdec_o(core_encdec_o),
    .core_block_o(core_block_o), .core_ready_i(core_ready_i), .core_result_i(core_result_i),
    .core_result_valid_i(core_result_valid_i), .grant_id_o(grant_id_o), .busy_o(busy_o),
    .blocks_done_o(blocks_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in for the AES core: FIPS-197 vector is exact, other inputs map through a keyed scramble.
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic kl,
                                           input logic enc, input logic [127:0] b);
    if (!kl && enc && k[255:128] == FIPS_KEY && b == FIPS_PT) return FIPS_CT;
    return {b[63:0], b[127:64]} ^ k[255:128] ^ (kl ? k[127:0] : 128'h0) ^ {128{~enc}};
  endfunction

  // Core model: busy for core_lat cycles after each strobe, expansion key captured on init.
  int           core_lat = 3;
  logic [255:0] ck;
  logic         ckl, cenc, cblk_mode;
  logic [127:0] cblk;
  int           ccnt;
  initial begin
    core_ready_i = 1'b1; core_result_valid_i = 1'b0; core_result_i = '0;
    ck = '0; ckl = 1'b0; cenc = 1'b0; cblk = '0; cblk_mode = 1'b0; ccnt = 0;
    forever begin
      @(posedge clk); #2;
      if (core_init_o) begin
        ck = core_key_o; ckl = core_keylen_o; cblk_mode = 1'b0; ccnt = core_lat;
        core_ready_i = 1'b0; core_result_valid_i = 1'b0;
      end else if (core_next_o) begin
        cblk = core_block_o; cenc = core_encdec_o; cblk_mode = 1'b1; ccnt = core_lat;
        core_ready_i = 1'b0; core_result_valid_i = 1'b0;
      end else if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) begin
          core_ready_i = 1'b1;
          if (cblk_mode) begin
            core_result_valid_i = 1'b1;
            core_result_i = core_fn(ck, ckl, cenc, cblk);
          end
        end
      end
    end
  end

  // Requester side: per-requester block queues, popped when accepted.
  logic [255:0] key_r [NB];
  logic         kl_r  [NB];
  logic         enc_r [NB];
  logic [127:0] q0[$];
  logic [127:0] q1[$];

  task automatic refresh();
    req_valid_i[0] = (q0.size() > 0);
    req_valid_i[1] = (q1.size() > 0);
    req_block_i[0*BW +: BW] = (q0.size() > 0) ? q0[0] : '0;
    req_block_i[1*BW +: BW] = (q1.size() > 0) ? q1[0] : '0;
    for (int i = 0; i < NB; i++) begin
      req_key_i[i*KW +: KW] = key_r[i];
      req_keylen_i[i] = kl_r[i];
      req_encdec_i[i] = enc_r[i];
    end
  endtask

  task automatic push(input int i, input logic [127:0] b);
    if (i == 0) q0.push_back(b);
    else q1.push_back(b);
    refresh();
  endtask

  initial begin
    logic [NB-1:0] gr;
    forever begin
      @(negedge clk);
      gr = reset_n ? req_ready_o : '0;
      @(posedge clk); #1;
      if (gr[0] && q0.size() > 0) void'(q0.pop_front());
      if (gr[1] && q1.size() > 0) void'(q1.pop_front());
      refresh();
    end
  end

  // Transaction-level model: one outstanding block, round-robin order, key context tracking.
  int           m_busy, m_ptr, m_g, m_owner, m_loaded, m_init_exp, just_granted;
  int           init_cnt, next_cnt, rsp_total = 0, tot_init = 0, tot_next = 0;
  logic [31:0]  m_done;
  logic [127:0] m_exp, m_blk;
  logic [255:0] m_key;
  logic         m_kl, m_enc;
  logic [127:0] rsp_log[$];
  int           grant_log[$];

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_g = 0; m_owner = 0; m_loaded = 0; m_done = '0;
    m_init_exp = 0; just_granted = 0; init_cnt = 0; next_cnt = 0;
  endtask

  always @(negedge clk) begin : model_cmp
    logic [NB-1:0] exp_rdy;
    int g;
    int idx;
    if (!reset_n) begin
      model_reset();
    end else begin
      exp_rdy = '0;
      g = -1;
      if (m_busy == 0 && !clear && core_ready_i) begin
        for (int k = 0; k < NB; k++) begin
          idx = (m_ptr + k) % NB;
          if (g < 0 && req_valid_i[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready_o, exp_rdy);
      chk("busy", busy_o, m_busy);
      chk("blocks_done", blocks_done_o, m_done);
      chk("grant_id", grant_id_o, m_g);
      if (rsp_valid_o != '0) begin
        chk("rsp_valid_owner", rsp_valid_o, (m_busy != 0) ? (NB'(1) << m_g) : '0);
        if (m_busy != 0) chk("rsp_block", rsp_block_o, m_exp);
      end
      if (just_granted != 0) begin
        chk("first_strobe", {core_init_o, core_next_o}, (m_init_exp != 0) ? 2'b10 : 2'b01);
        just_granted = 0;
      end
      if (core_init_o) begin
        init_cnt++; tot_init++;
        chk("core_key", core_key_o, m_key);
        chk("core_keylen", core_keylen_o, m_kl);
      end
      if (core_next_o) begin
        next_cnt++; tot_next++;
        chk("core_block", core_block_o, m_blk);
        chk("core_encdec", core_encdec_o, m_enc);
      end
      if (clear) begin
        model_reset();
      end else begin
        if (m_busy != 0 && rsp_valid_o[m_g] && rsp_ready_i[m_g]) begin
          chk("init_per_block", init_cnt, m_init_exp);
          chk("next_per_block", next_cnt, 1);
          rsp_log.push_back(rsp_block_o);
          m_done = m_done + 32'd1;
          rsp_total++;
          m_ptr = (m_g + 1) % NB;
          m_busy = 0;
        end
        if (key_update_i[m_owner]) m_loaded = 0;
        if (g >= 0) begin
          m_init_exp = (m_loaded != 0 && m_owner == g && !key_update_i[g]) ? 0 : 1;
          m_owner = g; m_loaded = 1; m_g = g; m_busy = 1;
          m_key = req_key_i[g*KW +: KW]; m_kl = req_keylen_i[g];
          m_enc = req_encdec_i[g]; m_blk = req_block_i[g*BW +: BW];
          m_exp = core_fn(m_key, m_kl, m_enc, m_blk);
          grant_log.push_back(g);
          init_cnt = 0; next_cnt = 0; just_granted = 1;
        end
      end
    end
  end

  task automatic wait_rsp(input int target, input string name);
    int k = 0;
    while (rsp_total < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(name, rsp_total >= target, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_strobe(input bit want_init);
    int k = 0;
    while (!(want_init ? core_init_o : core_next_o) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(want_init ? "init_seen" : "next_seen", want_init ? core_init_o : core_next_o, 1);
  endtask

  initial begin
    int base, tgt, rbase, k;
    logic [31:0] done_before;
    model_reset();
    reset_n = 1'b1; clear = 1'b0; key_update_i = '0; rsp_ready_i = '1;
    req_valid_i = '0; req_key_i = '0; req_block_i = '0; req_keylen_i = '0; req_encdec_i = '0;
    for (int i = 0; i < NB; i++) begin key_r[i] = '0; kl_r[i] = 1'b0; enc_r[i] = 1'b1; end
    #2 reset_n = 1'b0;
    #10;
    chk("rst_busy", busy_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_init", core_init_o, 0);
    chk("rst_next", core_next_o, 0);
    chk("rst_grant_id", grant_id_o, 0);
    chk("rst_blocks_done", blocks_done_o, 0);
    chk("rst_core_key", core_key_o, 0);
    chk("rst_core_block", core_block_o, 0);
    chk("rst_rsp_block", rsp_block_o, 0);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single requester, FIPS key, two blocks, slow core.
    core_lat = 10;
    key_r[0] = {FIPS_KEY, 128'h0}; kl_r[0] = 1'b0; enc_r[0] = 1'b1;
    base = tot_init; k = tot_next; rbase = rsp_log.size();
    push(0, FIPS_PT);
    push(0, 128'h0123456789abcdef0011223344556677);
    wait_rsp(2, "t1_done");
    chk("t1_fips_ct", rsp_log[rbase], FIPS_CT);
    chk("t1_blocks_done", blocks_done_o, 2);
    chk("t1_inits", tot_init - base, 1);
    chk("t1_nexts", tot_next - k, 2);

    // Two requesters, distinct keys, both continuously valid.
    clear = 1'b1; @(posedge clk); #1 clear = 1'b0;
    core_lat = 3;
    key_r[0] = {128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 128'h0};
    key_r[1] = {128'h0F0F_1234_5678_9ABC_DEF0_1357_9BDF_2468, 128'hCAFE_F00D_0000_0000_0000_0000_BEEF_0001};
    kl_r[1] = 1'b1; enc_r[1] = 1'b0;
    refresh();
    grant_log.delete();
    base = tot_init; tgt = rsp_total + 4;
    push(0, 128'h10); push(0, 128'h11); push(1, 128'h20); push(1, 128'h21);
    wait_rsp(tgt, "t2_done");
    chk("t2_grant_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("t2_g0", grant_log[0], 0); chk("t2_g1", grant_log[1], 1);
      chk("t2_g2", grant_log[2], 0); chk("t2_g3", grant_log[3], 1);
    end
    chk("t2_inits", tot_init - base, 4);
    chk("t2_blocks_done", blocks_done_o, 4);

    // Response back-pressure: result held, no new grant.
    rsp_ready_i = 2'b10; tgt = rsp_total + 2;
    push(0, 128'h30);
    k = 0;
    while (!rsp_valid_o[0] && k < 200) begin @(negedge clk); k++; end
    chk("t4_rsp_seen", rsp_valid_o[0], 1);
    push(1, 128'h31);
    done_before = blocks_done_o;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid_o, 2'b01);
      chk("t4_hold_no_grant", req_ready_o, 0);
      chk("t4_hold_done", blocks_done_o, done_before);
    end
    @(posedge clk); #1 rsp_ready_i = 2'b11;
    wait_rsp(tgt, "t4_done");

    // Key update of the owner while its block is in flight.
    base = tot_init; tgt = rsp_total + 1;
    push(0, 128'h40);
    wait_strobe(1'b0);
    @(posedge clk); #1;
    key_update_i = 2'b01;
    key_r[0] = {128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE, 128'h0};
    refresh();
    @(posedge clk); #1 key_update_i = '0;
    wait_rsp(tgt, "t5_inflight_done");
    chk("t5_inflight_init", tot_init - base, 1);
    base = tot_init; tgt = rsp_total + 1;
    push(0, 128'h41);
    wait_rsp(tgt, "t5_reload_done");
    chk("t5_reload_init", tot_init - base, 1);
    base = tot_init; tgt = rsp_total + 1;
    push(0, 128'h42);
    wait_rsp(tgt, "t5_reuse_done");
    chk("t5_reuse_init", tot_init - base, 0);

    // Soft clear during BLK_WAIT discards the block.
    tgt = rsp_total;
    push(0, 128'h50);
    wait_strobe(1'b0);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("t6_busy", busy_o, 0);
    chk("t6_rsp_valid", rsp_valid_o, 0);
    chk("t6_blocks_done", blocks_done_o, 0);
    chk("t6_no_rsp", rsp_total, tgt);
    base = tot_init; tgt = rsp_total + 1;
    push(0, 128'h51);
    wait_rsp(tgt, "t6_after_done");
    chk("t6_after_init", tot_init - base, 1);
    chk("t6_after_blocks", blocks_done_o, 1);

    // Asynchronous reset in the middle of KEY_WAIT.
    push(1, 128'h60);
    wait_strobe(1'b1);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("t7_busy", busy_o, 0);
    chk("t7_init", core_init_o, 0);
    chk("t7_grant_id", grant_id_o, 0);
    chk("t7_blocks_done", blocks_done_o, 0);
    chk("t7_core_key", core_key_o, 0);
    chk("t7_rsp_valid", rsp_valid_o, 0);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    base = tot_init; tgt = rsp_total + 1;
    push(1, 128'h61);
    wait_rsp(tgt, "t7_after_done");
    chk("t7_after_init", tot_init - base, 1);
    chk("t7_after_blocks", blocks_done_o, 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_core_sched.md
Name: aes_core_sched

Overview:
- Schedules a single AES core between NB_REQ block requesters.
- Each requester hands over one 128-bit block plus its key and mode. The scheduler grants requesters round-robin and runs key expansion only when the key context changes. It then pulses the core's next strobe, captures the result and returns it to the granted requester.
- Sits between per-context HWPE controllers and the shared AES core, replacing the fixed single-cycle "working" step with a real core handshake.

Parameters:
- NB_REQ, 2, number of requesters; 2..8.
- KEY_W, 256, key width in bits.
- BLK_W, 128, block width in bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous soft clear
- req_valid_i  in  NB_REQ  requester i has a block pending
- req_ready_o  out  NB_REQ  request i accepted this cycle
- req_key_i  in  NB_REQ*KEY_W  key of requester i, slice i
- req_keylen_i  in  NB_REQ  0 = 128-bit key, 1 = 256-bit key
- req_encdec_i  in  NB_REQ  1 = encrypt, 0 = decrypt
- req_block_i  in  NB_REQ*BLK_W  input block of requester i
- key_update_i  in  NB_REQ  pulse: requester i changed its key
- rsp_valid_o  out  NB_REQ  result valid for requester i
- rsp_ready_i  in  NB_REQ  requester i takes the result
- rsp_block_o  out  BLK_W  result block, shared bus
- core_init_o  out  1  one-cycle key-expansion strobe
- core_next_o  out  1  one-cycle block strobe
- core_key_o  out  KEY_W  latched key
- core_keylen_o  out  1  latched key length
- core_encdec_o  out  1  latched mode
- core_block_o  out  BLK_W  latched block
- core_ready_i  in  1  core idle
- core_result_i  in  BLK_W  core output
- core_result_valid_i  in  1  core result valid
- grant_id_o  out  $clog2(NB_REQ)  current/last owner
- busy_o  out  1  state != IDLE
- blocks_done_o  out  32  completed-block count, wraps

Behaviour:
- Reset/clear values: all outputs, rr_ptr, key_loaded, key_owner, grant_id_o and blocks_done_o are 0.
  - clear is equivalent to reset from any state. The in-flight block is discarded and no rsp_valid_o is raised.
- States: IDLE, KEY_INIT, KEY_WAIT, BLK_START, BLK_WAIT, RESP.
- IDLE, grant selection:
  - Pick the first requester with req_valid_i set, searching from rr_ptr upward modulo NB_REQ.
  - Grant only when core_ready_i = 1.
  - req_ready_o[g] = 1 for that single cycle. Key, keylen, encdec and block of g are latched into the core_* registers.
  - Next state is KEY_INIT if !key_loaded or key_owner != g; otherwise BLK_START.
- KEY_INIT: core_init_o = 1 for one cycle. key_owner <= g, key_loaded <= 0. Go to KEY_WAIT.
- KEY_WAIT:
  - core_ready_i is ignored in the first cycle (guard).
  - From the second cycle on, core_ready_i = 1 sets key_loaded <= 1 and moves to BLK_START.
- BLK_START: core_next_o = 1 for one cycle. Go to BLK_WAIT.
- BLK_WAIT:
  - Guard cycle as in KEY_WAIT.
  - Then core_ready_i && core_result_valid_i moves core_result_i into the result register and goes to RESP.
- RESP:
  - rsp_valid_o[g] = 1 and rsp_block_o = result register, held stable until rsp_ready_i[g].
  - On the handshake cycle: blocks_done_o increments (wrapping 0xFFFFFFFF -> 0), rr_ptr <= (g+1) mod NB_REQ, and the next state is IDLE.
  - The earliest next grant is the following cycle, so there is no back-to-back grant on the response cycle.
- Latency:
  - Key reuse: accept at T, core_next_o at T+1.
  - Key reload: core_init_o at T+1.
  - The response appears the cycle after the core result is captured.
- key_update_i[i]: if i == key_owner, key_loaded <= 0 in any state.
  - Currently loaded expansion is still used for the in-flight block.
  - The next grant to i reloads the key.
- Simultaneous events:
  - key_update_i in the same cycle as a KEY_WAIT completion: the update wins and key_loaded stays 0.
  - clear beats every other event.
- rsp_ready_i outside RESP, and rsp_ready_i of non-owners, are ignored.
- core_* outputs hold their last latched values until the next grant.
- Only the rsp_valid_o bit of the owner may be 1; at most one bit is set at a time.

Test Plan:
- Single requester 0, key K0, two blocks in sequence:
  - 1st block: exactly one core_init_o, then core_next_o.
  - 2nd block: core_next_o at T+1, no init.
  - blocks_done_o = 2.
- Requesters 0 and 1 both valid continuously, distinct keys:
  - Grants alternate 0,1,0,1.
  - core_init_o pulses on every grant.
  - grant_id_o follows the grant order.
- Model core with 10-cycle busy time:
  - No grant while core_ready_i = 0.
  - core_next_o is never asserted twice per block.
  - The FIPS-197 AES-128 vector (key 000102..0f, pt 00112233..ff) returns 69c4e0d86a7b0430d8cdb78070b4c55a on rsp_block_o.
- rsp_ready_i held low 5 cycles in RESP:
  - rsp_valid_o and rsp_block_o stay stable.
  - No new grant until the handshake.
- key_update_i[0] pulsed during BLK_WAIT of requester 0:
  - Current block completes normally.
  - The next request from 0 triggers core_init_o.
- clear asserted during BLK_WAIT:
  - The next cycle is IDLE, with no rsp_valid_o and blocks_done_o = 0.
  - The next grant performs key init.
  - reset_n asserted mid-KEY_WAIT: the same behaviour applies, asynchronously.
